// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives a 1-cycle-latency synchronous instruction memory,
// latches instruction/PC/valid and slices register-file address fields.
module fetch_stage #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
  parameter int unsigned           PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic                if_id_valid,
  output logic [2:0]          rf_read_addr1,
  output logic [2:0]          rf_read_addr2,
  output logic [2:0]          rf_br_addr,
  output logic [2:0]          rf_dest_addr,
  output logic                fetching
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] req_pc_q;
  logic                req_valid_q;

  // During a stall the in-flight address is re-issued so the returning
  // data stays aligned with req_pc_q; a branch always issues from pc_q.
  always_comb begin
    imem_addr = pc_q;
    if (state == RUN && stall && !branch_taken) begin
      imem_addr = req_pc_q;
    end
  end

  // Register-file address fields are raw slices; consumers qualify with valid.
  assign rf_read_addr1 = if_id_instr[23:21];
  assign rf_read_addr2 = if_id_instr[20:18];
  assign rf_br_addr    = if_id_instr[23:21];
  assign rf_dest_addr  = if_id_instr[26:24];

  // Fetch FSM, PC, in-flight request and IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetching    <= 1'b0;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetching    <= 1'b1;
          req_valid_q <= 1'b0;
        end

        RUN: begin
          // Priority: halt over branch over stall.
          if (halt) begin
            state       <= HALTED;
            fetching    <= 1'b0;
            req_valid_q <= 1'b0;
            if (!stall) begin
              if_id_instr <= imem_data;
              if_id_pc    <= req_pc_q;
              if_id_valid <= req_valid_q;
            end
          end else if (branch_taken) begin
            pc_q        <= branch_target;
            req_valid_q <= 1'b0;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
            pc_q        <= pc_q + PC_WIDTH'(PC_STEP);
            if_id_instr <= imem_data;
            if_id_pc    <= req_pc_q;
            if_id_valid <= req_valid_q;
          end
        end

        HALTED: begin
          fetching    <= 1'b0;
          req_valid_q <= 1'b0;
          if (!stall) begin
            if_id_instr <= imem_data;
            if_id_pc    <= req_pc_q;
            if_id_valid <= req_valid_q;
          end
        end

        default: begin
          state    <= BOOT;
          fetching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// stall/branch run checked against an instruction-stream reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [2:0]  rf_read_addr1;
  logic [2:0]  rf_read_addr2;
  logic [2:0]  rf_br_addr;
  logic [2:0]  rf_dest_addr;
  logic        fetching;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_br_addr    (rf_br_addr),
    .rf_dest_addr  (rf_dest_addr),
    .fetching      (fetching)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents; one special word for field-slice checks.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0540_0000;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk) imem_data <= mem_fn(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b1; halt = 1'b1;
    branch_target = 32'h0000_1234;
    tick(); tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_id_pc); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
    checks++; if (fetching !== 1'b0) begin errors++; $display("FAIL reset_fetching got %0b exp 0", fetching); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
    rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
  endtask

  task automatic test_sequential();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_valid cycle %0d got %0b exp 0", c, if_id_valid); end
      checks++; if (fetching !== 1'b1) begin errors++; $display("FAIL boot_fetching cycle %0d got %0b exp 1", c, fetching); end
    end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e;
      e = 32'(k) * 4;
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== e) begin errors++; $display("FAIL seq_pc got %h/%0b exp %h/1", if_id_pc, if_id_valid, e); end
      checks++; if (if_id_instr !== mem_fn(e)) begin errors++; $display("FAIL seq_instr got %h exp %h", if_id_instr, mem_fn(e)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr got %h exp c", imem_addr); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (if_id_pc !== 32'h8 || if_id_instr !== mem_fn(32'h8) || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold got %h/%h exp 8/%h", if_id_pc, if_id_instr, mem_fn(32'h8)); end
      checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr_hold got %h exp c", imem_addr); end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_pc !== 32'hC || if_id_instr !== mem_fn(32'hC)) begin errors++; $display("FAIL stall_release1 got %h/%h exp c", if_id_pc, if_id_instr); end
    tick();
    checks++; if (if_id_pc !== 32'h10 || if_id_instr !== mem_fn(32'h10)) begin errors++; $display("FAIL stall_release2 got %h/%h exp 10", if_id_pc, if_id_instr); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL branch_flush got %0b exp 0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL branch_bubble got %0b exp 0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== mem_fn(32'h100)) begin
      errors++; $display("FAIL branch_target got %h/%0b/%h exp 100/1/%h", if_id_pc, if_id_valid, if_id_instr, mem_fn(32'h100)); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h104) begin errors++; $display("FAIL branch_next got %h/%0b exp 104/1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_branch_stall();
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h40;
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL brstall_flush got %0b exp 0", if_id_valid); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL brstall_pc got %h exp 40", imem_addr); end
    branch_taken = 1'b0; stall = 1'b0;
    tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40) begin errors++; $display("FAIL brstall_target got %h/%0b exp 40/1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_rf_slices();
    logic [31:0] w;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    tick(); tick();
    checks++; if (if_id_instr !== 32'h0540_0000) begin errors++; $display("FAIL rf_instr got %h exp 05400000", if_id_instr); end
    checks++; if (rf_dest_addr !== 3'd5 || rf_read_addr1 !== 3'd2 || rf_read_addr2 !== 3'd0 || rf_br_addr !== 3'd2) begin
      errors++; $display("FAIL rf_slices got d%0d a1%0d a2%0d b%0d exp d5 a12 a20 b2", rf_dest_addr, rf_read_addr1, rf_read_addr2, rf_br_addr); end
    tick();
    w = mem_fn(32'h204);
    checks++; if (rf_dest_addr !== w[26:24] || rf_read_addr1 !== w[23:21] || rf_read_addr2 !== w[20:18] || rf_br_addr !== w[23:21]) begin
      errors++; $display("FAIL rf_slices2 got d%0d a1%0d a2%0d b%0d for %h", rf_dest_addr, rf_read_addr1, rf_read_addr2, rf_br_addr, w); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick(); tick();
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_top got %h/%0b exp fffffffc/1", if_id_pc, if_id_valid); end
    tick();
    checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== mem_fn(32'h0)) begin
      errors++; $display("FAIL wrap_zero got %h/%0b exp 0/1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_halt();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    checks++; if (if_id_pc !== 32'hC || imem_addr !== 32'h14) begin errors++; $display("FAIL halt_setup got %h/%h exp c/14", if_id_pc, imem_addr); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (if_id_pc !== 32'h10 || if_id_valid !== 1'b1) begin errors++; $display("FAIL halt_inflight got %h/%0b exp 10/1", if_id_pc, if_id_valid); end
    checks++; if (fetching !== 1'b0) begin errors++; $display("FAIL halt_fetching got %0b exp 0", fetching); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (if_id_valid !== 1'b0 || fetching !== 1'b0 || imem_addr !== 32'h14) begin
        errors++; $display("FAIL halted got v%0b f%0b addr %h exp v0 f0 14", if_id_valid, fetching, imem_addr); end
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || fetching !== 1'b1) begin
      errors++; $display("FAIL halt_restart got %h/%0b/%0b exp 0/1/1", if_id_pc, if_id_valid, fetching); end
  endtask

  // Stream model: after a redirect, one bubble-producing (unstalled) edge,
  // then instructions flow from the target in PC_STEP increments.
  task automatic test_random();
    logic        m_valid;
    logic [31:0] m_pc, exp_next;
    int          gap;
    int          local_err;
    logic        s, b;
    logic [31:0] t;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m_valid = 1'b0; m_pc = 32'h0; exp_next = 32'h0; gap = 1; local_err = 0;
    for (int c = 0; c < 400; c++) begin
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0;
      stall = s; branch_taken = b; branch_target = t;
      tick();
      if (b) begin
        m_valid = 1'b0; exp_next = t; gap = 1;
      end else if (!s) begin
        if (gap > 0) begin
          m_valid = 1'b0; gap--;
        end else begin
          m_valid = 1'b1; m_pc = exp_next; exp_next = exp_next + 32'd4;
        end
      end
      checks++;
      if (if_id_valid !== m_valid || (m_valid && (if_id_pc !== m_pc || if_id_instr !== mem_fn(m_pc)))) begin
        errors++;
        if (local_err < 5) $display("FAIL random cycle %0d got %h/%0b/%h exp %h/%0b/%h", c, if_id_pc, if_id_valid, if_id_instr, m_pc, m_valid, mem_fn(m_pc));
        local_err++;
      end
    end
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    branch_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_rf_slices();
    test_wrap();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
